// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated word RAM responder with a 16-bit test register
//
// Purpose: accepts one read/write request at a time, inserts WAIT_CYCLES wait
// states, then answers with a single-cycle ack. Word RAM occupies byte
// addresses 0 .. DEPTH_WORDS*4-1; a 16-bit test register lives at TEST_ADDR.
// Misaligned or unmapped accesses complete with err=1, rdata=0 and no update.
//
// Ports:
//   clock       rising-edge system clock
//   reset       asynchronous, active-high reset
//   req         request strobe, sampled only in IDLE
//   we          1 = write, 0 = read (qualified by req)
//   addr        byte address (qualified by req)
//   wdata       write data (qualified by req)
//   rdata       registered read response data
//   ack         registered one-cycle response pulse
//   err         error flag, valid with ack
//   test_value  registered test register contents
module data_mem_responder #(
  parameter int          WAIT_CYCLES = 2,
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] TEST_ADDR   = 32'h0000_0100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic [15:0] test_value
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the response is produced on the accepting edge, so
  // the operation must be taken from the live inputs while still in IDLE.
  logic          op_we;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic          addr_ok;
  logic          is_test;
  logic [AW-1:0] word_idx;
  logic          go_resp;
  logic          ram_we;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op_we    = (state == IDLE) ? we    : we_q;
    op_addr  = (state == IDLE) ? addr  : addr_q;
    op_wdata = (state == IDLE) ? wdata : wdata_q;
    is_test  = (op_addr == TEST_ADDR);
    addr_ok  = (op_addr[1:0] == 2'b00) && ((op_addr < RAM_BYTES) || is_test);
    word_idx = op_addr[AW+1:2];
    // RESP is entered from IDLE or WAIT only, never from itself.
    go_resp  = (state_nxt == RESP) && (state != RESP);
    // Gated by reset so a zero-wait request seen during reset cannot write.
    ram_we   = go_resp && addr_ok && op_we && !is_test && !reset;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      ack        <= 1'b0;
      err        <= 1'b0;
      rdata      <= 32'd0;
      test_value <= 16'd0;
    end else begin
      if (state == IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= WAIT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end

      ack <= go_resp;
      err <= go_resp && !addr_ok;

      if (go_resp) begin
        if (!addr_ok) begin
          rdata <= 32'd0;
        end else if (!op_we) begin
          rdata <= is_test ? {16'h0000, test_value} : mem[word_idx];
        end else if (is_test) begin
          test_value <= op_wdata[15:0];
        end
      end
    end
  end

  // RAM has no reset; contents survive reset by design.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      mem[word_idx] <= op_wdata;
    end
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 2: wait states between request acceptance and response (legal range 0..15).
REQ-002 SHALL provide parameter DEPTH_WORDS, default 64: RAM depth in 32-bit words, power of two.
REQ-003 SHALL provide parameter TEST_ADDR, default 32'h0000_0100: byte address of the test register (word-aligned, at or above DEPTH_WORDS*4).
REQ-004 SHALL have one clock; reset is asynchronous and active-high, with ports named clock and reset.
REQ-005 clock  input  1  rising-edge system clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req  input  1  initiator request strobe; sampled only in IDLE.
REQ-008 we  input  1  1 = write, 0 = read; qualified by req.
REQ-009 addr  input  32  byte address; qualified by req.
REQ-010 wdata  input  32  write data; qualified by req.
REQ-011 rdata  output  32  read response data, registered.
REQ-012 ack  output  1  one-cycle response pulse, registered.
REQ-013 err  output  1  error flag, valid only while ack=1.
REQ-014 test_value  output  16  test register contents, registered.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 IDLE with req=1 at a clock edge: latch addr, we and wdata. Go to WAIT with counter = WAIT_CYCLES, or to RESP if WAIT_CYCLES = 0.
REQ-017 IDLE with req=0: stay in IDLE.
REQ-018 WAIT: decrement the counter every cycle. When the counter is 1, go to RESP on the next edge. WAIT therefore lasts exactly WAIT_CYCLES cycles.
REQ-019 RESP: ack=1 for exactly one cycle, then unconditional return to IDLE.
REQ-020 Latency: for a request accepted at edge E, ack SHALL be high in the cycle following edge E+WAIT_CYCLES.
REQ-021 req, we, addr and wdata SHALL be ignored in WAIT and RESP. Changing them after acceptance SHALL not affect the transaction.
REQ-022 req held high continuously SHALL yield back-to-back transactions, one per WAIT_CYCLES+2 cycles.
REQ-023 Error condition: latched addr[1:0] != 0, or the address is neither below DEPTH_WORDS*4 nor equal to TEST_ADDR.
REQ-024 On error: err=1 with ack, rdata=0, and no RAM or test-register update.
REQ-025 Valid write to RAM: commit wdata to word addr[log2(DEPTH_WORDS)+1:2] on the edge entering RESP. rdata SHALL hold its previous value and err=0.
REQ-026 Valid read from RAM: load rdata on the edge entering RESP. rdata SHALL then hold until the next ack.
REQ-027 Write to TEST_ADDR: update test_value with wdata[15:0] on the edge entering RESP. RAM SHALL be unchanged.
REQ-028 Read from TEST_ADDR: rdata = {16'h0000, test_value}.
REQ-029 Read of a RAM word never written SHALL return the RAM's uninitialised contents. Benches SHALL not check it.
REQ-030 err SHALL be 0 whenever ack=0.

Reset
REQ-031 Asserting reset at any time, including mid-WAIT or in RESP, SHALL immediately force state IDLE, ack=0, err=0, rdata=0, test_value=0 and counter=0.
REQ-032 A transaction interrupted by reset SHALL be aborted: no RAM write, no test-register write, and no ack after reset releases.
REQ-033 RAM contents SHALL not be affected by reset.
REQ-034 The first request after reset deassertion SHALL be accepted on the first edge with req=1.

Verification
REQ-035 Write then read, WAIT_CYCLES=2: write 32'hDEADBEEF to addr 0x10 -> ack in cycle 3 after acceptance, err=0. Read 0x10 -> rdata=32'hDEADBEEF, ack cycle 3.
REQ-036 Test register: write 32'h1234ABCD to TEST_ADDR -> test_value=16'hABCD after ack. Read TEST_ADDR -> rdata=32'h0000ABCD.
REQ-037 Errors: read 0x12 -> ack with err=1, rdata=0. Write 0x200 (DEPTH 64) -> err=1, RAM and test_value unchanged.
REQ-038 Reset mid-WAIT during a write of 32'h55 to 0x20 -> ack never asserts. Reading 0x20 afterwards returns the prior contents. test_value=0.
REQ-039 req held high and inputs changed during WAIT -> only the latched transaction completes. The next acceptance occurs at the IDLE cycle after RESP.
REQ-040 WAIT_CYCLES=0: read accepted at edge E -> ack high in the cycle after E, with correct rdata.
